// File: rtl/board_state_pkg.sv
// Shared constants for the minesweeper board: state encodings, board geometry
// and the neighbour-mask helper used by both the adjacency counter and the top.
package board_state_pkg;

   localparam int          BOARD_W   = 8;
   localparam logic [5:0]  INIT_POS  = 6'd27;
   localparam logic [63:0] BOARD_ALL = {64{1'b1}};

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PLAY = 2'd1;
   localparam logic [1:0] ST_LOST = 2'd2;
   localparam logic [1:0] ST_WON  = 2'd3;

   // One bit per in-board neighbour of tile t; off-board offsets are dropped,
   // so there is no wrap across row or column ends.
   function automatic logic [63:0] nbr_mask(input logic [5:0] t);
      logic [63:0] m;
      logic [5:0]  idx;
      int          r;
      int          c;
      m = '0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            r = int'(t[5:3]) + dr;
            c = int'(t[2:0]) + dc;
            if (!(dr == 0 && dc == 0) && r >= 0 && r < BOARD_W &&
                c >= 0 && c < BOARD_W) begin
               idx = 6'(r * BOARD_W + c);
               m   = m | (64'd1 << idx);
            end
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/board_state_adj_counter.sv
// Counts the mines surrounding one tile (0..8). Purely combinational.
module adj_counter
   import board_state_pkg::*;
(
   input  logic [63:0] mine_map_i,
   input  logic [5:0]  tile_i,
   output logic [3:0]  count_o
);

   logic [63:0] hits;

   // Popcount of the mines that fall inside the tile's neighbourhood.
   always_comb begin
      hits    = mine_map_i & nbr_mask(tile_i);
      count_o = 4'd0;
      for (int i = 0; i < 64; i++) begin
         count_o = count_o + {3'b000, hits[0]};
         hits    = hits >> 1;
      end
   end

endmodule

// File: rtl/board_state.sv
// Minesweeper board owner: mine layout, flags, revealed tiles, cursor and
// game status, with one command accepted per cycle while playing.
module board_state
   import board_state_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        mine_load,
   input  logic [63:0] mine_in,
   input  logic        mv_up,
   input  logic        mv_down,
   input  logic        mv_left,
   input  logic        mv_right,
   input  logic        act_step,
   input  logic        act_flag,
   output logic [63:0] mineMap,
   output logic [63:0] flagMap,
   output logic [63:0] stepMap,
   output logic [63:0] posMap,
   output logic [3:0]  adj_count,
   output logic [1:0]  game_state
);

   logic [5:0]  pos_q,     pos_d;
   logic [63:0] mine_q,    mine_d;
   logic [63:0] flag_q,    flag_d;
   logic [63:0] step_q,    step_d;
   logic [63:0] posmap_q;
   logic [1:0]  state_q,   state_d;
   logic [3:0]  adj_w;
   logic [63:0] pos_bit;

   // Single adjacency counter on the cursor tile feeds both the output and
   // the neighbour-reveal decision.
   adj_counter u_adj (
      .mine_map_i (mine_q),
      .tile_i     (pos_q),
      .count_o    (adj_w)
   );

   assign pos_bit = 64'd1 << pos_q;

   // Next-state: mine_load wins everywhere, otherwise one prioritised command in PLAY.
   always_comb begin
      pos_d   = pos_q;
      mine_d  = mine_q;
      flag_d  = flag_q;
      step_d  = step_q;
      state_d = state_q;
      if (mine_load) begin
         mine_d  = mine_in;
         flag_d  = '0;
         step_d  = '0;
         pos_d   = INIT_POS;
         state_d = ST_PLAY;
      end else if (state_q == ST_PLAY) begin
         if (act_step) begin
            if (((flag_q & pos_bit) == '0) && ((step_q & pos_bit) == '0)) begin
               if ((mine_q & pos_bit) != '0) begin
                  step_d  = step_q | mine_q | pos_bit;
                  state_d = ST_LOST;
               end else begin
                  step_d = step_q | pos_bit;
                  // Single-level reveal: only direct neighbours, never recursive.
                  if (adj_w == 4'd0)
                     step_d = step_d | (nbr_mask(pos_q) & ~flag_q & ~mine_q);
                  if ((step_d | mine_q) == BOARD_ALL)
                     state_d = ST_WON;
               end
            end
         end else if (act_flag) begin
            if ((step_q & pos_bit) == '0)
               flag_d = flag_q ^ pos_bit;
         end else if (mv_up) begin
            if (pos_q[5:3] != 3'd0) pos_d = pos_q - 6'd8;
         end else if (mv_down) begin
            if (pos_q[5:3] != 3'd7) pos_d = pos_q + 6'd8;
         end else if (mv_left) begin
            if (pos_q[2:0] != 3'd0) pos_d = pos_q - 6'd1;
         end else if (mv_right) begin
            if (pos_q[2:0] != 3'd7) pos_d = pos_q + 6'd1;
         end
      end
   end

   // State registers; posMap is registered alongside the cursor so every map is a flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         pos_q    <= INIT_POS;
         posmap_q <= 64'd1 << INIT_POS;
         mine_q   <= '0;
         flag_q   <= '0;
         step_q   <= '0;
         state_q  <= ST_IDLE;
      end else begin
         pos_q    <= pos_d;
         posmap_q <= 64'd1 << pos_d;
         mine_q   <= mine_d;
         flag_q   <= flag_d;
         step_q   <= step_d;
         state_q  <= state_d;
      end
   end

   assign mineMap    = mine_q;
   assign flagMap    = flag_q;
   assign stepMap    = step_q;
   assign posMap     = posmap_q;
   assign adj_count  = adj_w;
   assign game_state = state_q;

endmodule
